bootram_arb: RTL

BOOTRAM_ARB -- requirements
Module: bootram_arb

---
 rtl/bootram_arb_pkg.sv | 13 +
 rtl/bootram_arb.sv | 119 +++++++++++
 2 files changed

// File: rtl/bootram_arb_pkg.sv
// Shared constants and FSM encoding for the boot RAM arbiter.
package bootram_arb_pkg;

  localparam int unsigned BOOT_LANES  = 4;
  localparam int unsigned BOOT_ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    LD_ACC  = 2'd2
  } state_e;

endpackage

// File: rtl/bootram_arb.sv
// Arbitrates the CPU port and the byte loader onto four 2Kx8 boot RAM lanes.
// A grant drives the RAM combinationally in the issue cycle; the following
// cycle carries the ready pulse and the registered RAM read data.
module bootram_arb
  import bootram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = BOOT_ADDR_W,
  parameter bit          LD_PRIO = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_valid,
  output logic                    cpu_ready,
  input  logic [ADDR_W+1:0]       cpu_addr,
  input  logic [BOOT_LANES-1:0]   cpu_wstrb,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [ADDR_W+1:0]       ld_addr,
  input  logic [7:0]              ld_data,
  output logic [ADDR_W-1:0]       ram_ad,
  output logic [BOOT_LANES-1:0]   ram_ce,
  output logic [BOOT_LANES-1:0]   ram_wre,
  output logic                    ram_oce,
  output logic [31:0]             ram_din,
  input  logic [31:0]             ram_dout,
  output logic                    busy
);

  state_e      state_q, state_d;
  logic        prefer_ld_q, prefer_ld_d;   // 1: loader wins the next tie
  logic        rd_q, rd_d;                 // in-flight CPU access is a read
  logic [31:0] rdata_q;
  logic        grant_cpu, grant_ld;
  logic [BOOT_LANES-1:0] lane_oh;

  // Byte offset is irrelevant for word-wide CPU accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign ram_oce = 1'b1;

  // State, fairness token, read flag and held read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prefer_ld_q <= LD_PRIO;
      rd_q        <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      prefer_ld_q <= prefer_ld_d;
      rd_q        <= rd_d;
      if (state_q == CPU_ACC && rd_q) begin
        rdata_q <= ram_dout;
      end
    end
  end

  // Arbitration, next state and RAM/handshake drive.
  always_comb begin
    state_d     = state_q;
    prefer_ld_d = prefer_ld_q;
    rd_d        = rd_q;
    grant_cpu   = 1'b0;
    grant_ld    = 1'b0;
    lane_oh     = {{(BOOT_LANES-1){1'b0}}, 1'b1} << ld_addr[1:0];
    ram_ad      = '0;
    ram_ce      = '0;
    ram_wre     = '0;
    ram_din     = 32'h0;
    cpu_ready   = 1'b0;
    ld_ready    = 1'b0;
    busy        = 1'b0;
    cpu_rdata   = rdata_q;

    case (state_q)
      IDLE: begin
        // reset also gates the issue path so the RAM sees no enables
        grant_ld  = !reset && ld_valid && (!cpu_valid || prefer_ld_q);
        grant_cpu = !reset && cpu_valid && !grant_ld;
        if (grant_cpu) begin
          ram_ad      = cpu_addr[ADDR_W+1:2];
          ram_din     = cpu_wdata;
          ram_ce      = '1;
          ram_wre     = cpu_wstrb;
          rd_d        = (cpu_wstrb == '0);
          prefer_ld_d = 1'b1;
          state_d     = CPU_ACC;
        end else if (grant_ld) begin
          ram_ad      = ld_addr[ADDR_W+1:2];
          ram_din     = {BOOT_LANES{ld_data}};
          ram_ce      = lane_oh;
          ram_wre     = lane_oh;
          prefer_ld_d = 1'b0;
          state_d     = LD_ACC;
        end
      end
      CPU_ACC: begin
        cpu_ready = 1'b1;
        busy      = 1'b1;
        if (rd_q) begin
          cpu_rdata = ram_dout;
        end
        state_d   = IDLE;
      end
      LD_ACC: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
